// File: rtl/main_ctrl_fsm_if.sv
`default_nettype none
// ============================================================================
//  Module   : main_ctrl_fsm_if
//  Brief    : Control bundle between the multi-cycle main control FSM and the
//             datapath: instruction opcode and memory handshake in, datapath
//             control strobes/selects and debug state out.
//  Revision : 1.0 - initial release
// ============================================================================
interface main_ctrl_fsm_if;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       pc_write;
  logic       pc_write_cond;
  logic       i_or_d;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       mem_to_reg;
  logic       reg_dst;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] pc_source;
  logic [1:0] alu_ct_op;
  logic       illegal_op;
  logic [3:0] state;

  // Controller side: consumes opcode/handshake, drives controls
  modport master (
    input  opcode, mem_ready,
    output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, pc_source,
           alu_ct_op, illegal_op, state
  );

  // Datapath side: supplies opcode/handshake, consumes controls
  modport slave (
    output opcode, mem_ready,
    input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, pc_source,
           alu_ct_op, illegal_op, state
  );
endinterface
`default_nettype wire

// File: rtl/main_ctrl_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : main_ctrl_fsm
//  Brief    : Multi-cycle MIPS-style main controller. Moore FSM sequencing
//             fetch/decode/execute/memory/write-back, with optional memory
//             wait states and an illegal-opcode pulse.
//  Revision : 1.0 - initial release
// ============================================================================
module main_ctrl_fsm #(
  parameter int MEM_WAIT_EN = 1
) (
  input wire logic        clk,
  input wire logic        rst,
  main_ctrl_fsm_if.master bus
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_R_EXEC   = 4'd6,
    S_R_WB     = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_I_EXEC   = 4'd10,
    S_I_WB     = 4'd11
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  state_e     state_q, state_d;

  logic       ready_w;
  logic       pc_write_w, pc_write_cond_w, i_or_d_w, mem_read_w, mem_write_w;
  logic       ir_write_w, mem_to_reg_w, reg_dst_w, reg_write_w, alu_src_a_w;
  logic       illegal_op_w;
  logic [1:0] alu_src_b_w, pc_source_w, alu_ct_op_w;

  // With waits disabled the memory is treated as always ready
  assign ready_w = (MEM_WAIT_EN != 0) ? bus.mem_ready : 1'b1;

  // State register; reset returns to FETCH immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  // Next-state and Moore output decode (FETCH strobes gated by ready)
  always_comb begin
    state_d         = state_q;
    pc_write_w      = 1'b0;
    pc_write_cond_w = 1'b0;
    i_or_d_w        = 1'b0;
    mem_read_w      = 1'b0;
    mem_write_w     = 1'b0;
    ir_write_w      = 1'b0;
    mem_to_reg_w    = 1'b0;
    reg_dst_w       = 1'b0;
    reg_write_w     = 1'b0;
    alu_src_a_w     = 1'b0;
    alu_src_b_w     = 2'b00;
    pc_source_w     = 2'b00;
    alu_ct_op_w     = 2'b00;
    illegal_op_w    = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_read_w  = 1'b1;
        alu_src_b_w = 2'b01;
        ir_write_w  = ready_w;
        pc_write_w  = ready_w;
        if (ready_w) state_d = S_DECODE;
      end
      S_DECODE: begin
        alu_src_b_w = 2'b11;
        case (bus.opcode)
          OP_LW, OP_SW: state_d = S_MEM_ADDR;
          OP_RTYPE:     state_d = S_R_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          OP_ADDIU:     state_d = S_I_EXEC;
          default: begin
            state_d      = S_FETCH;
            illegal_op_w = 1'b1;
          end
        endcase
      end
      S_MEM_ADDR: begin
        alu_src_a_w = 1'b1;
        alu_src_b_w = 2'b10;
        state_d     = (bus.opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        mem_read_w = 1'b1;
        i_or_d_w   = 1'b1;
        if (ready_w) state_d = S_MEM_WB;
      end
      S_MEM_WB: begin
        reg_write_w  = 1'b1;
        mem_to_reg_w = 1'b1;
        state_d      = S_FETCH;
      end
      S_MEM_WR: begin
        mem_write_w = 1'b1;
        i_or_d_w    = 1'b1;
        if (ready_w) state_d = S_FETCH;
      end
      S_R_EXEC: begin
        alu_src_a_w = 1'b1;
        alu_ct_op_w = 2'b10;
        state_d     = S_R_WB;
      end
      S_R_WB: begin
        reg_write_w = 1'b1;
        reg_dst_w   = 1'b1;
        state_d     = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a_w     = 1'b1;
        alu_ct_op_w     = 2'b01;
        pc_write_cond_w = 1'b1;
        pc_source_w     = 2'b01;
        state_d         = S_FETCH;
      end
      S_JUMP: begin
        pc_write_w  = 1'b1;
        pc_source_w = 2'b10;
        state_d     = S_FETCH;
      end
      S_I_EXEC: begin
        alu_src_a_w = 1'b1;
        alu_src_b_w = 2'b10;
        state_d     = S_I_WB;
      end
      S_I_WB: begin
        reg_write_w = 1'b1;
        state_d     = S_FETCH;
      end
      // Unused codes 12-15 recover to FETCH with all outputs idle
      default: state_d = S_FETCH;
    endcase
  end

  // Reset forces every output low combinationally, independent of clk
  assign bus.pc_write      = ~rst & pc_write_w;
  assign bus.pc_write_cond = ~rst & pc_write_cond_w;
  assign bus.i_or_d        = ~rst & i_or_d_w;
  assign bus.mem_read      = ~rst & mem_read_w;
  assign bus.mem_write     = ~rst & mem_write_w;
  assign bus.ir_write      = ~rst & ir_write_w;
  assign bus.mem_to_reg    = ~rst & mem_to_reg_w;
  assign bus.reg_dst       = ~rst & reg_dst_w;
  assign bus.reg_write     = ~rst & reg_write_w;
  assign bus.alu_src_a     = ~rst & alu_src_a_w;
  assign bus.illegal_op    = ~rst & illegal_op_w;
  assign bus.alu_src_b     = rst ? 2'b00 : alu_src_b_w;
  assign bus.pc_source     = rst ? 2'b00 : pc_source_w;
  assign bus.alu_ct_op     = rst ? 2'b00 : alu_ct_op_w;
  assign bus.state         = rst ? 4'd0  : state_q;

endmodule
`default_nettype wire

// File: tb/tb_main_ctrl_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : tb_main_ctrl_fsm
//  Brief    : Directed self-checking bench for main_ctrl_fsm (wait-enabled
//             instance plus a wait-disabled instance with mem_ready tied low).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_main_ctrl_fsm;

  localparam logic [5:0] LW    = 6'b100011;
  localparam logic [5:0] SW    = 6'b101011;
  localparam logic [5:0] RT    = 6'b000000;
  localparam logic [5:0] BEQ   = 6'b000100;
  localparam logic [5:0] JMP   = 6'b000010;
  localparam logic [5:0] ADDIU = 6'b001001;
  localparam logic [5:0] ILL   = 6'b111111;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  main_ctrl_fsm_if bus1 ();
  main_ctrl_fsm_if bus2 ();

  main_ctrl_fsm #(.MEM_WAIT_EN(1)) u_dut_wait (.clk(clk), .rst(rst), .bus(bus1));
  main_ctrl_fsm #(.MEM_WAIT_EN(0)) u_dut_nowait (.clk(clk), .rst(rst), .bus(bus2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Drive inputs for the current cycle, then check state and exclusivity rules
  task automatic cyc(input logic rdy, input logic [5:0] op, input logic [3:0] exp_state);
    bus1.mem_ready = rdy;
    bus1.opcode    = op;
    #1;
    chk("state", bus1.state, exp_state);
    chk("rd_wr_excl", bus1.mem_read & bus1.mem_write, 0);
    chk("rw_wr_excl", bus1.reg_write & bus1.mem_write, 0);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst            = 1'b1;
    bus1.mem_ready = 1'b1;
    bus1.opcode    = LW;
    bus2.mem_ready = 1'b0;
    bus2.opcode    = JMP;

    // Reset holds everything low, even FETCH strobes with mem_ready high
    #2;
    chk("rst_state", bus1.state, 0);
    chk("rst_mem_read", bus1.mem_read, 0);
    chk("rst_pc_write", bus1.pc_write, 0);
    chk("rst_alu_src_b", bus1.alu_src_b, 0);
    tick;
    tick;
    chk("rst_state2", bus1.state, 0);
    chk("rst_ir_write2", bus1.ir_write, 0);
    rst = 1'b0;

    // lw with 2 FETCH waits and 1 MEM_RD wait: 0,0,0,1,2,3,3,4
    cyc(0, LW, 0);
    chk("lw_f0_mem_read", bus1.mem_read, 1);
    chk("lw_f0_ir_write", bus1.ir_write, 0);
    chk("lw_f0_pc_write", bus1.pc_write, 0);
    chk("lw_f0_alu_src_b", bus1.alu_src_b, 1);
    tick;
    cyc(0, LW, 0);
    chk("lw_f1_mem_read", bus1.mem_read, 1);
    chk("lw_f1_alu_src_b", bus1.alu_src_b, 1);
    chk("lw_f1_ir_write", bus1.ir_write, 0);
    tick;
    cyc(1, LW, 0);
    chk("lw_f2_ir_write", bus1.ir_write, 1);
    chk("lw_f2_pc_write", bus1.pc_write, 1);
    tick;
    cyc(1, LW, 1);
    chk("lw_dec_alu_src_b", bus1.alu_src_b, 3);
    chk("lw_dec_reg_write", bus1.reg_write, 0);
    tick;
    cyc(1, LW, 2);
    chk("lw_addr_alu_src_a", bus1.alu_src_a, 1);
    chk("lw_addr_alu_src_b", bus1.alu_src_b, 2);
    tick;
    cyc(0, LW, 3);
    chk("lw_rd_mem_read", bus1.mem_read, 1);
    chk("lw_rd_i_or_d", bus1.i_or_d, 1);
    chk("lw_rd_reg_write", bus1.reg_write, 0);
    tick;
    cyc(1, LW, 3);
    chk("lw_rd2_i_or_d", bus1.i_or_d, 1);
    tick;
    cyc(1, LW, 4);
    chk("lw_wb_reg_write", bus1.reg_write, 1);
    chk("lw_wb_mem_to_reg", bus1.mem_to_reg, 1);
    chk("lw_wb_reg_dst", bus1.reg_dst, 0);
    tick;

    // R-type: 0,1,6,7
    cyc(1, RT, 0);
    chk("r_f_reg_write", bus1.reg_write, 0);
    tick;
    cyc(1, RT, 1);
    tick;
    cyc(1, RT, 6);
    chk("r_exec_alu_ct_op", bus1.alu_ct_op, 2);
    chk("r_exec_alu_src_b", bus1.alu_src_b, 0);
    tick;
    cyc(1, RT, 7);
    chk("r_wb_reg_dst", bus1.reg_dst, 1);
    chk("r_wb_reg_write", bus1.reg_write, 1);
    tick;

    // beq: 0,1,8
    cyc(1, BEQ, 0);
    tick;
    cyc(1, BEQ, 1);
    tick;
    cyc(1, BEQ, 8);
    chk("beq_alu_ct_op", bus1.alu_ct_op, 1);
    chk("beq_pc_write_cond", bus1.pc_write_cond, 1);
    chk("beq_pc_source", bus1.pc_source, 1);
    chk("beq_pc_write", bus1.pc_write, 0);
    tick;

    // Illegal opcode: 0,1 then FETCH; pulse only in DECODE
    cyc(1, ILL, 0);
    chk("ill_f_illegal", bus1.illegal_op, 0);
    tick;
    cyc(1, ILL, 1);
    chk("ill_dec_illegal", bus1.illegal_op, 1);
    chk("ill_dec_reg_write", bus1.reg_write, 0);
    chk("ill_dec_mem_write", bus1.mem_write, 0);
    chk("ill_dec_pc_write", bus1.pc_write, 0);
    tick;

    // addiu: 0,1,10,11
    cyc(1, ADDIU, 0);
    chk("ill_after_illegal", bus1.illegal_op, 0);
    tick;
    cyc(1, ADDIU, 1);
    tick;
    cyc(1, ADDIU, 10);
    chk("addiu_alu_src_b", bus1.alu_src_b, 2);
    chk("addiu_alu_src_a", bus1.alu_src_a, 1);
    tick;
    cyc(1, ADDIU, 11);
    chk("addiu_reg_write", bus1.reg_write, 1);
    chk("addiu_reg_dst", bus1.reg_dst, 0);
    tick;

    // sw stalled in MEM_WR, then aborted by reset
    cyc(1, SW, 0);
    tick;
    cyc(1, SW, 1);
    tick;
    cyc(1, SW, 2);
    tick;
    cyc(0, SW, 5);
    chk("sw_wr_mem_write", bus1.mem_write, 1);
    chk("sw_wr_i_or_d", bus1.i_or_d, 1);
    chk("sw_wr_mem_read", bus1.mem_read, 0);
    tick;
    cyc(0, SW, 5);
    chk("sw_wait_mem_write", bus1.mem_write, 1);
    rst = 1'b1;
    #1;
    chk("sw_rst_mem_write", bus1.mem_write, 0);
    chk("sw_rst_state", bus1.state, 0);
    tick;
    chk("sw_rst_edge_mem_write", bus1.mem_write, 0);
    rst = 1'b0;

    // After release: wait instance idles in FETCH; no-wait instance runs j
    cyc(0, SW, 0);
    chk("sw_post0_mem_write", bus1.mem_write, 0);
    chk("j_f_state", bus2.state, 0);
    chk("j_f_pc_write", bus2.pc_write, 1);
    chk("j_f_ir_write", bus2.ir_write, 1);
    tick;
    cyc(0, SW, 0);
    chk("sw_post1_mem_write", bus1.mem_write, 0);
    chk("j_dec_state", bus2.state, 1);
    chk("j_dec_pc_write", bus2.pc_write, 0);
    tick;
    cyc(0, SW, 0);
    chk("sw_post2_mem_write", bus1.mem_write, 0);
    chk("j_jump_state", bus2.state, 9);
    chk("j_jump_pc_write", bus2.pc_write, 1);
    chk("j_jump_pc_source", bus2.pc_source, 2);
    tick;
    chk("j_done_state", bus2.state, 0);
    chk("sw_post3_mem_write", bus1.mem_write, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/main_ctrl_fsm.md
MAIN_CTRL_FSM -- requirements
Module: main_ctrl_fsm

Interface
REQ-001 Parameter MEM_WAIT_EN, default 1: 1 = FETCH/MEM_RD/MEM_WR hold until mem_ready; 0 = mem_ready is ignored and treated as 1.
REQ-002 clk  input  1  single clock; all state updates occur on the rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 opcode  input  6  instruction bits [31:26] from the instruction register; stable from DECODE onward.
REQ-005 mem_ready  input  1  memory access completes this cycle.
REQ-006 pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a  output  1 each  datapath controls.
REQ-007 alu_src_b  output  2  ALU B select: 00 = reg B, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate shifted left by 2.
REQ-008 pc_source  output  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target.
REQ-009 alu_ct_op  output  2  to the ALU control decoder: 00 = add, 01 = subtract, 10 = use funct.
REQ-010 illegal_op  output  1  one-cycle pulse when an unsupported opcode is decoded.
REQ-011 state  output  4  current state encoding, for debug.

Function
REQ-012 State encoding SHALL be: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_RD=3, MEM_WB=4, MEM_WR=5, R_EXEC=6, R_WB=7, BRANCH=8, JUMP=9, I_EXEC=10, I_WB=11; codes 12-15 SHALL go to FETCH on the next edge.
REQ-013 Outputs SHALL be Moore, decoded from state only, except ir_write and pc_write in FETCH, which are gated by mem_ready.
REQ-014 Any output not listed for a state in REQ-015 to REQ-026 SHALL be 0 in that state.
REQ-015 FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_ct_op=00, pc_source=00, ir_write=pc_write=mem_ready; hold until mem_ready, then go to DECODE.
REQ-016 DECODE: alu_src_a=0, alu_src_b=11, alu_ct_op=00. Next state by opcode: 100011 or 101011 -> MEM_ADDR; 000000 -> R_EXEC; 000100 -> BRANCH; 000010 -> JUMP; 001001 -> I_EXEC; any other -> FETCH with illegal_op=1 in this cycle.
REQ-017 MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_ct_op=00; go to MEM_RD if opcode=100011, else MEM_WR.
REQ-018 MEM_RD: mem_read=1, i_or_d=1; hold until mem_ready, then go to MEM_WB.
REQ-019 MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0; go to FETCH.
REQ-020 MEM_WR: mem_write=1, i_or_d=1; hold until mem_ready, then go to FETCH.
REQ-021 R_EXEC: alu_src_a=1, alu_src_b=00, alu_ct_op=10; go to R_WB.
REQ-022 R_WB: reg_write=1, reg_dst=1, mem_to_reg=0; go to FETCH.
REQ-023 BRANCH: alu_src_a=1, alu_src_b=00, alu_ct_op=01, pc_write_cond=1, pc_source=01; go to FETCH.
REQ-024 JUMP: pc_write=1, pc_source=10; go to FETCH.
REQ-025 I_EXEC: alu_src_a=1, alu_src_b=10, alu_ct_op=00; go to I_WB.
REQ-026 I_WB: reg_write=1, reg_dst=0, mem_to_reg=0; go to FETCH.
REQ-027 Cycle counts with mem_ready=1 throughout: lw 5, sw 4, R-type 4, addiu 4, beq 3, j 3, illegal 2.
REQ-028 mem_write and mem_read SHALL never both be 1; reg_write and mem_write SHALL never both be 1.
REQ-029 Each mem_ready wait cycle SHALL hold every output steady, except ir_write/pc_write, which stay 0 until mem_ready.

Reset
REQ-030 While rst=1: state=FETCH and every output=0, forced combinationally regardless of clk.
REQ-031 On the first rising edge after rst falls, the block SHALL be in FETCH with REQ-015 outputs active.
REQ-032 rst asserted in any state, including mid-wait, SHALL abort the instruction with no further write strobes.

Verification
REQ-033 lw (100011), mem_ready low 2 cycles in FETCH and 1 cycle in MEM_RD -> states 0,0,0,1,2,3,3,4,0; reg_write=1 only in state 4.
REQ-034 R-type (000000), mem_ready=1 -> states 0,1,6,7,0; alu_ct_op=10 in state 6; reg_dst=1 and reg_write=1 in state 7.
REQ-035 beq (000100) -> states 0,1,8,0; in state 8: alu_ct_op=01, pc_write_cond=1, pc_source=01.
REQ-036 opcode 111111 -> states 0,1,0; illegal_op=1 for exactly the DECODE cycle; no write strobes.
REQ-037 sw with mem_ready=0 in MEM_WR, then rst pulsed -> mem_write drops to 0 immediately; after release, state=0 and mem_write is never re-asserted.
REQ-038 MEM_WAIT_EN=0, mem_ready tied 0 -> j (000010) completes as 0,1,9,0 with pc_write=1 in FETCH and JUMP.
